wb_master_arb2: RTL and testbench
=================================

# wb_master_arb2

Two-port Wishbone master arbiter that shares one register-bank slave (e.g. the threshold register block) between two on-chip requesters, such as a host bridge and a local calibration sequencer. It accepts single-word read/write requests, grants the bus round-robin, and drives one transaction at a time onto a pipelined Wishbone master port. It returns read data, an ack or an error to the winning requester, and guards against a hung slave with an optional watchdog.

## Interface
- ADDR_WIDTH, 8, width of request and Wishbone address
- TIMEOUT_CYCLES, 255, watchdog limit in cycles (1..2^16-1); only used with the watchdog compiled in
- clk_i  in  1  single clock; everything is rising-edge
- rst_n_i  in  1  reset is synchronous and active-low
- req_i  in  2  per-requester request, level, held until its ack_o/err_o
- req_we_i  in  2  per-requester write enable
- req_adr_i  in  2×ADDR_WIDTH  per-requester address (packed [1:0][ADDR_WIDTH-1:0])
- req_dat_i  in  2×32  per-requester write data
- req_sel_i  in  2×4  per-requester byte selects
- ack_o  out  2  one-cycle completion pulse per requester
- err_o  out  2  one-cycle error pulse per requester (slave err or timeout)
- rdat_o  out  32  read data, valid while the matching ack_o is high; shared by both requesters
- wb_cyc_o, wb_stb_o, wb_we_o  out  1  Wishbone master controls
- wb_adr_o  out  ADDR_WIDTH; wb_dat_o  out  32; wb_sel_o  out  4
- wb_dat_i  in  32; wb_ack_i, wb_err_i, wb_stall_i  in  1

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: when any req_i is set, select the winner. Latch its we/adr/dat/sel into the Wishbone output registers and go to ISSUE.
- Arbitration: round-robin on a 1-bit last-served pointer. If exactly one requester is active, it wins. If both are active, the one not served last wins. The pointer updates on every grant and resets to 1, so requester 0 wins the first tie.
- ISSUE: cyc=1, stb=1. Hold stb and all signals while wb_stall_i=1.
  - Stall low with ack or err in the same cycle: complete, go to RESP.
  - Stall low without ack or err: go to WAIT.
- WAIT: cyc=1, stb=0. On wb_ack_i or wb_err_i, go to RESP.
- Completion: on the completing edge, drop cyc and stb. Capture wb_dat_i into rdat_o only for reads.
- RESP: pulse ack_o[g] on a slave ack, or err_o[g] on a slave err. If ack and err arrive together, err takes priority. Next state is IDLE.
- A requester dropping req_i mid-transaction does not abort the transaction; its ack/err still pulses. An ack or err arriving outside ISSUE/WAIT is ignored.
- At most one transaction is outstanding. cyc never rises on a cycle where it fell.

## Timing
- Reset values: all outputs 0; FSM in IDLE; pointer = 1; watchdog counter 0.
- Reset mid-operation: on the next edge, cyc/stb drop and the FSM returns to IDLE. No ack or err is issued and the in-flight request is lost.
- req_i sampled high in IDLE at edge N gives cyc/stb high after edge N.
- Zero-wait slave (ack in the first ISSUE cycle) gives ack_o high on the following cycle. Minimum request-to-ack is 3 cycles.
- Back-to-back: the next grant is evaluated in the IDLE cycle after RESP, so the minimum request spacing is 3 cycles.

## Configuration
- WB_MASTER_ARB2_TIMEOUT_EN defined: a 16-bit counter clears in IDLE and increments each cycle in ISSUE or WAIT.
  - When the counter reaches TIMEOUT_CYCLES, force completion: drop cyc/stb, go to RESP and pulse err_o[g].
  - rdat_o is left unchanged on a timeout.
- Macro undefined: no counter; the arbiter waits indefinitely for ack or err.

## Structure
- Package wb_master_arb2_pkg: FSM state enum (IDLE, ISSUE, WAIT, RESP) and a request struct (we, adr, dat, sel).
- Sub-module rr_arb2: a combinational winner-select plus the registered last-served pointer, with inputs req and advance and output grant index.

## Test plan
- Single read, requester 0, adr 0x00. The slave returns 0xA5A5_1234 with no wait state. Required: ack_o[0] 3 cycles after req, rdat_o=0xA5A5_1234, wb_we_o=0.
- Both requesters assert a write in the same cycle from reset. Required: requester 0 served first, then requester 1, with no cyc gap shorter than 1 cycle. A second tie then goes to requester 0.
- Slave holds wb_stall_i for 4 cycles. Required: stb and adr/dat stable for all 5 ISSUE cycles; ack follows.
- Slave asserts wb_err_i and wb_ack_i together. Required: err_o[1] pulses and ack_o stays 0.
- With WB_MASTER_ARB2_TIMEOUT_EN and TIMEOUT_CYCLES=10, the slave never responds. Required: cyc drops after 10 cycles, err_o[0] pulses once, and the arbiter returns to IDLE and serves the next request.
- rst_n_i low for one cycle during WAIT. Required: cyc=0 next cycle, no ack/err pulse, and a fresh request afterwards completes normally.

Source files
------------

// File: rtl/wb_master_arb2_pkg.sv
// Shared types for the two-port Wishbone master arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package wb_master_arb2_pkg;

    // Widest address the request record can carry; the top zero-extends
    // into it and truncates back to ADDR_WIDTH on the bus.
    localparam int REQ_ADR_W = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    // One captured single-word request as it is presented on the bus.
    typedef struct packed {
        logic                 we;
        logic [REQ_ADR_W-1:0] adr;
        logic [31:0]          dat;
        logic [3:0]           sel;
    } wb_req_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin winner select with a registered last-served pointer.
// Latency: grant is combinational from req; pointer updates on the edge where advance=1.
// Backpressure: none; the caller asserts advance only when it accepts the grant.
// Ports: req (2 request levels), advance (grant taken this cycle), grant (winner index).
module rr_arb2 (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic [1:0] req,
    input  logic       advance,
    output logic       grant
);

    logic last_q;

    // A lone requester always wins; on a tie the one not served last wins.
    always_comb begin
        grant = 1'b0;
        case (req)
            2'b10:   grant = 1'b1;
            2'b11:   grant = ~last_q;
            default: grant = 1'b0;
        endcase
    end

    // Pointer starts at 1 so requester 0 takes the first tie.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            last_q <= 1'b1;
        end else if (advance) begin
            last_q <= grant;
        end
    end

endmodule

// File: rtl/wb_master_arb2.sv
// Shares one pipelined Wishbone slave between two single-word requesters, round-robin.
// Latency: req sampled in IDLE -> cyc/stb next cycle; zero-wait slave -> ack_o one cycle after ISSUE.
// Backpressure: stb and request fields held while wb_stall_i=1; one transaction outstanding.
// Ports: req_* (per-requester request bundle), ack_o/err_o/rdat_o (responses),
//        wb_* (Wishbone master port). Optional watchdog: WB_MASTER_ARB2_TIMEOUT_EN.
module wb_master_arb2
    import wb_master_arb2_pkg::*;
#(
    parameter int ADDR_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                       clk_i,
    input  logic                       rst_n_i,
    input  logic [1:0]                 req_i,
    input  logic [1:0]                 req_we_i,
    input  logic [1:0][ADDR_WIDTH-1:0] req_adr_i,
    input  logic [1:0][31:0]           req_dat_i,
    input  logic [1:0][3:0]            req_sel_i,
    output logic [1:0]                 ack_o,
    output logic [1:0]                 err_o,
    output logic [31:0]                rdat_o,
    output logic                       wb_cyc_o,
    output logic                       wb_stb_o,
    output logic                       wb_we_o,
    output logic [ADDR_WIDTH-1:0]      wb_adr_o,
    output logic [31:0]                wb_dat_o,
    output logic [3:0]                 wb_sel_o,
    input  logic [31:0]                wb_dat_i,
    input  logic                       wb_ack_i,
    input  logic                       wb_err_i,
    input  logic                       wb_stall_i
);

    state_t  state_q, state_d;
    logic    gnt;        // current arbitration winner
    logic    gnt_q;      // requester owning the transaction in flight
    logic    grant_en;   // accept the winner this cycle
    logic    cmpl;       // transaction finishes on this edge
    logic    cmpl_err;   // ... and finishes with an error
    logic    cmpl_rd;    // ... and returns slave read data
    logic    timeout;    // watchdog expiry this cycle
    logic    busy;
    wb_req_t win;
    wb_req_t wb_q;

    rr_arb2 u_rr_arb2 (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .req     (req_i),
        .advance (grant_en),
        .grant   (gnt)
    );

    assign busy = (state_q == ISSUE) || (state_q == WAIT);

`ifdef WB_MASTER_ARB2_TIMEOUT_EN
    logic [15:0] wd_cnt_q;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            wd_cnt_q <= '0;
        end else if (state_q == IDLE) begin
            wd_cnt_q <= '0;
        end else if (busy) begin
            wd_cnt_q <= wd_cnt_q + 16'd1;
        end
    end

    // Fires on the edge the counter would reach the limit, so cyc stays
    // high for exactly TIMEOUT_CYCLES cycles.
    assign timeout = busy && (wd_cnt_q == 16'(TIMEOUT_CYCLES - 1));
`else
    assign timeout = 1'b0;

    // The limit only matters with the watchdog compiled in.
    if (TIMEOUT_CYCLES < 1) begin : g_timeout_unused
    end
`endif

    always_comb begin
        win.we  = req_we_i[gnt];
        win.adr = REQ_ADR_W'(req_adr_i[gnt]);
        win.dat = req_dat_i[gnt];
        win.sel = req_sel_i[gnt];
    end

    always_comb begin
        state_d  = state_q;
        grant_en = 1'b0;
        cmpl     = 1'b0;
        cmpl_err = 1'b0;
        cmpl_rd  = 1'b0;
        case (state_q)
            IDLE: begin
                if (|req_i) begin
                    grant_en = 1'b1;
                    state_d  = ISSUE;
                end
            end
            ISSUE: begin
                // A real slave response beats a coincident watchdog expiry.
                if (!wb_stall_i && (wb_ack_i || wb_err_i)) begin
                    cmpl     = 1'b1;
                    cmpl_err = wb_err_i;
                    cmpl_rd  = ~wb_q.we;
                    state_d  = RESP;
                end else if (timeout) begin
                    cmpl     = 1'b1;
                    cmpl_err = 1'b1;
                    state_d  = RESP;
                end else if (!wb_stall_i) begin
                    state_d  = WAIT;
                end
            end
            WAIT: begin
                if (wb_ack_i || wb_err_i) begin
                    cmpl     = 1'b1;
                    cmpl_err = wb_err_i;
                    cmpl_rd  = ~wb_q.we;
                    state_d  = RESP;
                end else if (timeout) begin
                    cmpl     = 1'b1;
                    cmpl_err = 1'b1;
                    state_d  = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            wb_q   <= '0;
            gnt_q  <= 1'b0;
            rdat_o <= '0;
            ack_o  <= '0;
            err_o  <= '0;
        end else begin
            ack_o <= '0;
            err_o <= '0;
            if (grant_en) begin
                wb_q  <= win;
                gnt_q <= gnt;
            end
            if (cmpl) begin
                if (cmpl_err) begin
                    err_o[gnt_q] <= 1'b1;
                end else begin
                    ack_o[gnt_q] <= 1'b1;
                end
                if (cmpl_rd) begin
                    rdat_o <= wb_dat_i;
                end
            end
        end
    end

    // cyc/stb decode straight from the state register; RESP always separates
    // a falling cyc from the next rising one.
    assign wb_cyc_o = busy;
    assign wb_stb_o = (state_q == ISSUE);
    assign wb_we_o  = wb_q.we;
    assign wb_adr_o = ADDR_WIDTH'(wb_q.adr);
    assign wb_dat_o = wb_q.dat;
    assign wb_sel_o = wb_q.sel;

endmodule

// File: tb/tb_wb_master_arb2.sv
module tb_wb_master_arb2;

    localparam logic [7:0]  A0 = 8'h00;
    localparam logic [7:0]  A1 = 8'h44;
    localparam logic [31:0] D0 = 32'h0000_00D0;
    localparam logic [31:0] D1 = 32'h1111_00D1;
    localparam logic [3:0]  S0 = 4'hF;
    localparam logic [3:0]  S1 = 4'h3;

    logic            clk_i = 1'b0;
    logic            rst_n_i;
    logic [1:0]      req_i, req_we_i;
    logic [1:0][7:0] req_adr_i;
    logic [1:0][31:0] req_dat_i;
    logic [1:0][3:0] req_sel_i;
    logic [1:0]      ack_o, err_o;
    logic [31:0]     rdat_o;
    logic            wb_cyc_o, wb_stb_o, wb_we_o;
    logic [7:0]      wb_adr_o;
    logic [31:0]     wb_dat_o;
    logic [3:0]      wb_sel_o;
    logic [31:0]     wb_dat_i;
    logic            wb_ack_i, wb_err_i, wb_stall_i;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    always #5 clk_i = ~clk_i;

    wb_master_arb2 #(.ADDR_WIDTH(8), .TIMEOUT_CYCLES(10)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i),
        .req_i(req_i), .req_we_i(req_we_i), .req_adr_i(req_adr_i),
        .req_dat_i(req_dat_i), .req_sel_i(req_sel_i),
        .ack_o(ack_o), .err_o(err_o), .rdat_o(rdat_o),
        .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
        .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o),
        .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i),
        .wb_stall_i(wb_stall_i)
    );

    // One clocked vector: inputs driven before the edge, outputs expected after it.
    // own: 0 = bus registers at reset value, 1 = requester 0 latched, 2 = requester 1 latched.
    typedef struct {
        logic        rst_n;
        logic [1:0]  req, we;
        logic        ack, err, stall;
        logic [31:0] sdat;
        logic        cyc, stb;
        logic [1:0]  own;
        logic        wwe;
        logic [1:0]  eack, eerr;
        logic        chk_rdat;
        logic [31:0] rdat;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(logic rst_n, logic [1:0] req, logic [1:0] we, logic ack,
                                logic err, logic stall, logic [31:0] sdat, logic cyc,
                                logic stb, logic [1:0] own, logic wwe, logic [1:0] eack,
                                logic [1:0] eerr, logic chk_rdat, logic [31:0] rdat);
        vec_t v;
        v.rst_n = rst_n; v.req = req; v.we = we; v.ack = ack; v.err = err;
        v.stall = stall; v.sdat = sdat; v.cyc = cyc; v.stb = stb; v.own = own;
        v.wwe = wwe; v.eack = eack; v.eerr = eerr; v.chk_rdat = chk_rdat; v.rdat = rdat;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act !== exp) begin
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end else begin
            pass_cnt++;
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_slave();
        wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_stall_i = 1'b0; wb_dat_i = '0;
    endtask

    task automatic do_reset();
        rst_n_i = 1'b0; req_i = '0; req_we_i = '0; idle_slave();
        step();
        rst_n_i = 1'b1;
    endtask

    initial begin
        logic [7:0]  eadr;
        logic [31:0] edat;
        logic [3:0]  esel;
        int          n_ack, cyc_cnt, err_cnt, ack_cnt, bad;

        req_adr_i[0] = A0; req_adr_i[1] = A1;
        req_dat_i[0] = D0; req_dat_i[1] = D1;
        req_sel_i[0] = S0; req_sel_i[1] = S1;
        rst_n_i = 1'b0; req_i = '0; req_we_i = '0; idle_slave();

        // reset state
        vq.push_back(mk(0, 2'b00, 2'b00, 0, 0, 0, 32'h0,       0, 0, 0, 0, 2'b00, 2'b00, 1, 32'h0));
        // single zero-wait read from requester 0: ack in the third cycle
        vq.push_back(mk(1, 2'b01, 2'b00, 0, 0, 0, 32'h0,       1, 1, 1, 0, 2'b00, 2'b00, 1, 32'h0));
        vq.push_back(mk(1, 2'b01, 2'b00, 1, 0, 0, 32'hA5A51234, 0, 0, 1, 0, 2'b01, 2'b00, 1, 32'hA5A51234));
        vq.push_back(mk(1, 2'b00, 2'b00, 0, 0, 0, 32'h0,       0, 0, 1, 0, 2'b00, 2'b00, 1, 32'hA5A51234));
        // tie from reset: requester 0 first, then 1; writes leave rdat alone
        vq.push_back(mk(0, 2'b00, 2'b00, 0, 0, 0, 32'h0,       0, 0, 0, 0, 2'b00, 2'b00, 1, 32'h0));
        vq.push_back(mk(1, 2'b11, 2'b11, 0, 0, 0, 32'h0,       1, 1, 1, 1, 2'b00, 2'b00, 1, 32'h0));
        vq.push_back(mk(1, 2'b11, 2'b11, 1, 0, 0, 32'hDEADBEEF, 0, 0, 1, 1, 2'b01, 2'b00, 1, 32'h0));
        vq.push_back(mk(1, 2'b10, 2'b11, 0, 0, 0, 32'h0,       0, 0, 1, 1, 2'b00, 2'b00, 1, 32'h0));
        vq.push_back(mk(1, 2'b10, 2'b11, 0, 0, 0, 32'h0,       1, 1, 2, 1, 2'b00, 2'b00, 1, 32'h0));
        vq.push_back(mk(1, 2'b10, 2'b11, 1, 0, 0, 32'h0,       0, 0, 2, 1, 2'b10, 2'b00, 1, 32'h0));
        vq.push_back(mk(1, 2'b00, 2'b00, 0, 0, 0, 32'h0,       0, 0, 2, 1, 2'b00, 2'b00, 1, 32'h0));
        // second tie goes back to requester 0
        vq.push_back(mk(1, 2'b11, 2'b00, 0, 0, 0, 32'h0,       1, 1, 1, 0, 2'b00, 2'b00, 1, 32'h0));
        vq.push_back(mk(1, 2'b11, 2'b00, 1, 0, 0, 32'h0BADF00D, 0, 0, 1, 0, 2'b01, 2'b00, 1, 32'h0BADF00D));
        vq.push_back(mk(1, 2'b00, 2'b00, 0, 0, 0, 32'h0,       0, 0, 1, 0, 2'b00, 2'b00, 1, 32'h0BADF00D));
        // stall for 4 cycles: 5 ISSUE cycles with stable fields, then ack
        vq.push_back(mk(1, 2'b10, 2'b10, 0, 0, 0, 32'h0,       1, 1, 2, 1, 2'b00, 2'b00, 1, 32'h0BADF00D));
        for (int k = 0; k < 4; k++)
            vq.push_back(mk(1, 2'b10, 2'b10, 0, 0, 1, 32'h0,   1, 1, 2, 1, 2'b00, 2'b00, 1, 32'h0BADF00D));
        vq.push_back(mk(1, 2'b10, 2'b10, 1, 0, 0, 32'h0,       0, 0, 2, 1, 2'b10, 2'b00, 1, 32'h0BADF00D));
        vq.push_back(mk(1, 2'b00, 2'b00, 0, 0, 0, 32'h0,       0, 0, 2, 1, 2'b00, 2'b00, 1, 32'h0BADF00D));
        // one wait state through WAIT
        vq.push_back(mk(1, 2'b01, 2'b00, 0, 0, 0, 32'h0,       1, 1, 1, 0, 2'b00, 2'b00, 1, 32'h0BADF00D));
        vq.push_back(mk(1, 2'b01, 2'b00, 0, 0, 0, 32'h0,       1, 0, 1, 0, 2'b00, 2'b00, 1, 32'h0BADF00D));
        vq.push_back(mk(1, 2'b01, 2'b00, 1, 0, 0, 32'h12345678, 0, 0, 1, 0, 2'b01, 2'b00, 1, 32'h12345678));
        vq.push_back(mk(1, 2'b00, 2'b00, 0, 0, 0, 32'h0,       0, 0, 1, 0, 2'b00, 2'b00, 1, 32'h12345678));
        // ack and err together: err wins for requester 1
        vq.push_back(mk(1, 2'b10, 2'b00, 0, 0, 0, 32'h0,       1, 1, 2, 0, 2'b00, 2'b00, 1, 32'h12345678));
        vq.push_back(mk(1, 2'b10, 2'b00, 1, 1, 0, 32'hCAFE0000, 0, 0, 2, 0, 2'b00, 2'b10, 0, 32'h0));
        vq.push_back(mk(1, 2'b00, 2'b00, 0, 0, 0, 32'h0,       0, 0, 2, 0, 2'b00, 2'b00, 0, 32'h0));
        // stray ack in IDLE is ignored
        vq.push_back(mk(1, 2'b00, 2'b00, 1, 0, 0, 32'h0,       0, 0, 2, 0, 2'b00, 2'b00, 0, 32'h0));
        // requester drops req mid-transaction; its ack still pulses
        vq.push_back(mk(1, 2'b01, 2'b01, 0, 0, 0, 32'h0,       1, 1, 1, 1, 2'b00, 2'b00, 0, 32'h0));
        vq.push_back(mk(1, 2'b00, 2'b00, 0, 0, 0, 32'h0,       1, 0, 1, 1, 2'b00, 2'b00, 0, 32'h0));
        vq.push_back(mk(1, 2'b00, 2'b00, 1, 0, 0, 32'h0,       0, 0, 1, 1, 2'b01, 2'b00, 0, 32'h0));
        vq.push_back(mk(1, 2'b00, 2'b00, 0, 0, 0, 32'h0,       0, 0, 1, 1, 2'b00, 2'b00, 0, 32'h0));
        // reset during WAIT: everything drops, no pulse, next request is clean
        vq.push_back(mk(1, 2'b01, 2'b00, 0, 0, 0, 32'h0,       1, 1, 1, 0, 2'b00, 2'b00, 0, 32'h0));
        vq.push_back(mk(1, 2'b01, 2'b00, 0, 0, 0, 32'h0,       1, 0, 1, 0, 2'b00, 2'b00, 0, 32'h0));
        vq.push_back(mk(0, 2'b01, 2'b00, 1, 0, 0, 32'h0,       0, 0, 0, 0, 2'b00, 2'b00, 1, 32'h0));
        vq.push_back(mk(1, 2'b00, 2'b00, 0, 0, 0, 32'h0,       0, 0, 0, 0, 2'b00, 2'b00, 1, 32'h0));
        vq.push_back(mk(1, 2'b01, 2'b00, 0, 0, 0, 32'h0,       1, 1, 1, 0, 2'b00, 2'b00, 1, 32'h0));
        vq.push_back(mk(1, 2'b01, 2'b00, 1, 0, 0, 32'h55AA55AA, 0, 0, 1, 0, 2'b01, 2'b00, 1, 32'h55AA55AA));
        vq.push_back(mk(1, 2'b00, 2'b00, 0, 0, 0, 32'h0,       0, 0, 1, 0, 2'b00, 2'b00, 1, 32'h55AA55AA));

        foreach (vq[i]) begin
            rst_n_i = vq[i].rst_n; req_i = vq[i].req; req_we_i = vq[i].we;
            wb_ack_i = vq[i].ack; wb_err_i = vq[i].err; wb_stall_i = vq[i].stall;
            wb_dat_i = vq[i].sdat;
            step();
            case (vq[i].own)
                2'd1:    begin eadr = A0; edat = D0; esel = S0; end
                2'd2:    begin eadr = A1; edat = D1; esel = S1; end
                default: begin eadr = '0; edat = '0; esel = '0; end
            endcase
            chk($sformatf("v%0d cyc", i), 32'(wb_cyc_o), 32'(vq[i].cyc));
            chk($sformatf("v%0d stb", i), 32'(wb_stb_o), 32'(vq[i].stb));
            chk($sformatf("v%0d we", i),  32'(wb_we_o),  32'(vq[i].wwe));
            chk($sformatf("v%0d adr", i), 32'(wb_adr_o), 32'(eadr));
            chk($sformatf("v%0d dat", i), wb_dat_o, edat);
            chk($sformatf("v%0d sel", i), 32'(wb_sel_o), 32'(esel));
            chk($sformatf("v%0d ack", i), 32'(ack_o), 32'(vq[i].eack));
            chk($sformatf("v%0d err", i), 32'(err_o), 32'(vq[i].eerr));
            if (vq[i].chk_rdat)
                chk($sformatf("v%0d rdat", i), rdat_o, vq[i].rdat);
        end

        // Back-to-back with both requesters always asserted and a zero-wait
        // slave: acks every 3 cycles, alternating 0,1,0,1.
        do_reset();
        req_i = 2'b11; req_we_i = 2'b00;
        n_ack = 0;
        for (int c = 0; c < 12; c++) begin
            wb_ack_i = wb_stb_o;
            step();
            if (ack_o != 2'b00) begin
                chk($sformatf("b2b ack%0d cycle", n_ack), 32'(c), 32'(1 + 3 * n_ack));
                chk($sformatf("b2b ack%0d owner", n_ack), 32'(ack_o), (n_ack % 2 == 0) ? 32'd1 : 32'd2);
                n_ack++;
            end
        end
        chk("b2b ack count", 32'(n_ack), 32'd4);
        req_i = 2'b00; idle_slave();
        step(); step();

`ifdef WB_MASTER_ARB2_TIMEOUT_EN
        // Silent slave: watchdog ends the cycle after 10 cycles with one err.
        do_reset();
        req_i = 2'b01; req_we_i = 2'b00;
        step();
        cyc_cnt = 0; err_cnt = 0; ack_cnt = 0;
        for (int c = 0; c < 40; c++) begin
            if (wb_cyc_o) cyc_cnt++;
            if (err_o[0]) begin err_cnt++; req_i = 2'b00; end
            if (ack_o != 2'b00) ack_cnt++;
            step();
        end
        chk("timeout cyc cycles", 32'(cyc_cnt), 32'd10);
        chk("timeout err pulses", 32'(err_cnt), 32'd1);
        chk("timeout no ack", 32'(ack_cnt), 32'd0);
        chk("timeout rdat kept", rdat_o, 32'h0);
        req_i = 2'b10; req_we_i = 2'b10;
        step();
        chk("after timeout issue adr", 32'(wb_adr_o), 32'(A1));
        wb_ack_i = 1'b1;
        step();
        chk("after timeout ack", 32'(ack_o), 32'd2);
        req_i = 2'b00; idle_slave();
        step();
`else
        // Without the watchdog a silent slave holds the bus indefinitely.
        do_reset();
        req_i = 2'b01; req_we_i = 2'b00;
        step();
        bad = 0;
        for (int c = 0; c < 300; c++) begin
            if (!wb_cyc_o || ack_o != 2'b00 || err_o != 2'b00) bad++;
            step();
        end
        chk("hung slave cycle held", 32'(bad), 32'd0);
        wb_ack_i = 1'b1; wb_dat_i = 32'h0000_0077;
        step();
        chk("hung slave late ack", 32'(ack_o), 32'd1);
        chk("hung slave late rdat", rdat_o, 32'h0000_0077);
        req_i = 2'b00; idle_slave();
        step();
`endif

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
